// File: rtl/eth_sw_pkg.sv
// eth_sw_pkg: shared FSM states and bus widths for the switch frame arbiter
package eth_sw_pkg;
    localparam int IN_W       = 128;
    localparam int SW_W       = 64;
    localparam int TAG_W      = 10;
    localparam int IN_BYTES_W = 4;
    localparam int SW_BYTES_W = 3;
    typedef enum logic [1:0] {IDLE, WAIT, HI, LO} state_t;
endpackage

// File: rtl/eth_rr_pick.sv
// eth_rr_pick: combinational round-robin pick of the first request at or after ptr
// req: request vector; ptr: start index; gnt: one-hot winner; idx: winner index; any: some request set
module eth_rr_pick #(
    parameter int N_REQ = 4,
    localparam int GW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [GW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [GW-1:0]    idx,
    output logic             any
);
    // Scan from the farthest offset down so the nearest request at or after ptr wins
    always_comb begin
        idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % N_REQ]) idx = GW'((int'(ptr) + k) % N_REQ);
    end
    assign any = |req;
    assign gnt = any ? N_REQ'(1) << idx : '0;
endmodule

// File: rtl/eth_sw_frame_arbiter.sv
// eth_sw_frame_arbiter: frame-level round-robin arbiter, 128-bit ingress beats onto a 64-bit switch bus
// clock/rst: system clock, synchronous active-high reset
// req_*: per-requester beats (valid, data, bytes-1, sof, eof, tag) with req_ready backpressure
// sw_*: registered 64-bit egress beats (valid, data, bytes-1, sof, eof, tag)
// grant_id/busy: bus owner and frame in progress; err_nosof/err_midsof: protocol error pulses
module eth_sw_frame_arbiter
    import eth_sw_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int GW = $clog2(N_REQ)
) (
    input  logic                        clock,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*IN_W-1:0]       req_data,
    input  logic [N_REQ*IN_BYTES_W-1:0] req_bytes,
    input  logic [N_REQ-1:0]            req_sof,
    input  logic [N_REQ-1:0]            req_eof,
    input  logic [N_REQ*TAG_W-1:0]      req_block_tag,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        sw_data_valid,
    output logic [SW_W-1:0]             sw_data,
    output logic [SW_BYTES_W-1:0]       sw_data_bytes,
    output logic                        sw_sof,
    output logic                        sw_eof,
    output logic [TAG_W-1:0]            sw_block_tag,
    output logic [GW-1:0]               grant_id,
    output logic                        busy,
    output logic                        err_nosof,
    output logic                        err_midsof
);
    state_t                state, state_nx;
    logic [IN_W-1:0]       hold;
    logic                  hold_eof, hold_first;
    logic [IN_BYTES_W-1:0] hold_bytes;
    logic [TAG_W-1:0]      tag;
    logic [GW-1:0]         rr_ptr, win, sel;
    logic [N_REQ-1:0]      win_oh, elig, drop;
    logic                  win_any, acc, fin;

    eth_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req (elig),
        .ptr (rr_ptr),
        .gnt (win_oh),
        .idx (win),
        .any (win_any)
    );

    assign elig = req_valid & req_sof;
    assign drop = req_valid & ~req_sof;
    assign sel  = state == IDLE ? win : grant_id;
    // HI is only ever entered on an accepted beat
    assign acc  = state_nx == HI;
    // Frame ends on the upper half when the eof beat carries at most 8 bytes, else on the lower half
    assign fin  = hold_eof && ((state == HI && hold_bytes < IN_BYTES_W'(8)) || state == LO);
    assign busy = state != IDLE;
    assign sw_block_tag = tag;

    always_ff @(posedge clock)
        state <= rst ? IDLE : state_nx;

    always_comb begin
        state_nx  = state;
        req_ready = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    req_ready = win_oh | drop;
                    state_nx  = win_any ? HI : IDLE;
                end
                HI: state_nx = fin ? IDLE : LO;
                LO: begin
                    req_ready[grant_id] = !fin;
                    state_nx = fin ? IDLE : req_valid[grant_id] ? HI : WAIT;
                end
                default: begin
                    req_ready[grant_id] = 1'b1;
                    state_nx = req_valid[grant_id] ? HI : WAIT;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            hold          <= '0;
            hold_eof      <= 1'b0;
            hold_first    <= 1'b0;
            hold_bytes    <= '0;
            tag           <= '0;
            rr_ptr        <= '0;
            grant_id      <= '0;
            sw_data_valid <= 1'b0;
            sw_data       <= '0;
            sw_data_bytes <= '0;
            sw_sof        <= 1'b0;
            sw_eof        <= 1'b0;
            err_nosof     <= 1'b0;
            err_midsof    <= 1'b0;
        end else begin
            sw_data_valid <= state == HI || state == LO;
            sw_sof        <= state == HI && hold_first;
            sw_eof        <= fin;
            if (state == HI || state == LO) begin
                sw_data <= state == HI ? hold[IN_W-1:SW_W] : hold[SW_W-1:0];
                // Low three bits give bytes on a short upper half and bytes-8 on a final lower half
                sw_data_bytes <= fin ? hold_bytes[SW_BYTES_W-1:0] : SW_BYTES_W'(7);
            end
            if (acc) begin
                hold       <= req_data[sel*IN_W +: IN_W];
                hold_eof   <= req_eof[sel];
                hold_bytes <= req_bytes[sel*IN_BYTES_W +: IN_BYTES_W];
            end
            if (state == IDLE && win_any) begin
                grant_id <= win;
                tag      <= req_block_tag[win*TAG_W +: TAG_W];
            end
            hold_first <= state == IDLE || (hold_first && state != HI);
            if (fin) rr_ptr <= grant_id == GW'(N_REQ - 1) ? '0 : grant_id + 1'b1;
            err_nosof  <= state == IDLE && |drop;
            err_midsof <= acc && state != IDLE && req_sof[grant_id];
        end
    end
endmodule

// File: tb/tb_eth_sw_frame_arbiter.sv
// tb_eth_sw_frame_arbiter: randomized frames checked against a frame-level round-robin reference model
module tb_eth_sw_frame_arbiter;
    localparam int N = 4;

    typedef struct {
        logic [127:0] d;
        logic         sof;
        logic         eof;
        logic [3:0]   bytes;
        logic [9:0]   tag;
        int           gap;
    } beat_t;

    typedef struct {
        logic [63:0] d;
        logic [2:0]  bytes;
        logic        sof;
        logic        eof;
        logic [9:0]  tag;
    } swb_t;

    logic           clock_tb = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_sof, req_eof, req_ready;
    logic [N*128-1:0] req_data;
    logic [N*4-1:0] req_bytes;
    logic [N*10-1:0] req_block_tag;
    logic           sw_data_valid, sw_sof, sw_eof, busy, err_nosof, err_midsof;
    logic [63:0]    sw_data;
    logic [2:0]     sw_data_bytes;
    logic [9:0]     sw_block_tag;
    logic [1:0]     grant_id;

    beat_t txq[N][$];
    swb_t  exp_r[N][$];
    int    checks = 0, errors = 0;
    int    mptr = 0, cur = 0, sof_seen = 0;
    int    exp_mid = 0, mid_seen = 0, nos_seen = 0;

    eth_sw_frame_arbiter #(.N_REQ(N)) dut (
        .clock         (clock_tb),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_bytes     (req_bytes),
        .req_sof       (req_sof),
        .req_eof       (req_eof),
        .req_block_tag (req_block_tag),
        .req_ready     (req_ready),
        .sw_data_valid (sw_data_valid),
        .sw_data       (sw_data),
        .sw_data_bytes (sw_data_bytes),
        .sw_sof        (sw_sof),
        .sw_eof        (sw_eof),
        .sw_block_tag  (sw_block_tag),
        .grant_id      (grant_id),
        .busy          (busy),
        .err_nosof     (err_nosof),
        .err_midsof    (err_midsof)
    );

    always #5 clock_tb = ~clock_tb;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int rr_win(input logic [N-1:0] e, input int p);
        for (int k = 0; k < N; k++)
            if (e[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // Queue a frame for requester r and derive its egress beats from the down-conversion rules
    task automatic enq(input int r, input int nb, input logic [3:0] lb, input logic [9:0] tag,
                       input int gap_at, input int gap_len, input int mid_at);
        beat_t b;
        swb_t  s;
        for (int i = 0; i < nb; i++) begin
            b.d     = {$urandom, $urandom, $urandom, $urandom};
            b.sof   = i == 0 || i == mid_at;
            b.eof   = i == nb - 1;
            b.bytes = b.eof ? lb : 4'($urandom);
            b.tag   = i == 0 ? tag : 10'($urandom);
            b.gap   = i == gap_at ? gap_len : 0;
            txq[r].push_back(b);
            if (i > 0 && i == mid_at) exp_mid++;
            s.tag   = tag;
            s.d     = b.d[127:64];
            s.sof   = i == 0;
            s.eof   = b.eof && lb < 8;
            s.bytes = s.eof ? lb[2:0] : 3'd7;
            exp_r[r].push_back(s);
            if (!s.eof) begin
                s.d     = b.d[63:0];
                s.sof   = 1'b0;
                s.eof   = b.eof;
                s.bytes = b.eof ? 3'(lb - 8) : 3'd7;
                exp_r[r].push_back(s);
            end
        end
    endtask

    task automatic stray(input int r);
        beat_t b;
        b.d = {$urandom, $urandom, $urandom, $urandom};
        b.sof = 1'b0;
        b.eof = 1'b0;
        b.bytes = 4'd0;
        b.tag = 10'd0;
        b.gap = 0;
        txq[r].push_back(b);
    endtask

    function automatic bit pending();
        for (int r = 0; r < N; r++)
            if (txq[r].size() > 0 || exp_r[r].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain(input int budget);
        int k = 0;
        while ((pending() || busy) && k < budget) begin
            @(negedge clock_tb);
            #1;
            k++;
        end
        check("drain_done", k < budget, 1'b1);
    endtask

    // Monitor at negedge, requester drivers just after posedge
    initial begin
        logic [N-1:0] took, e1, e2;
        swb_t x;
        beat_t b;
        int w;
        took = '0;
        e1 = '0;
        e2 = '0;
        forever begin
            @(negedge clock_tb);
            took = req_valid & req_ready;
            if (!rst) begin
                if (busy) check("exclusive_ready", req_ready & ~(N'(1) << grant_id), '0);
                if (sw_data_valid) begin
                    if (sw_sof) begin
                        w = rr_win(e2, mptr);
                        check("grant", grant_id, w);
                        cur = w < 0 ? 0 : w;
                        sof_seen = 1;
                    end
                    check("beat_expected", exp_r[cur].size() > 0, 1'b1);
                    if (exp_r[cur].size() > 0) begin
                        x = exp_r[cur].pop_front();
                        check("sw_data", sw_data, x.d);
                        check("sw_bytes", sw_data_bytes, x.bytes);
                        check("sw_sof", sw_sof, x.sof);
                        check("sw_eof", sw_eof, x.eof);
                        check("sw_tag", sw_block_tag, x.tag);
                    end
                    if (sw_eof) mptr = (cur + 1) % N;
                end
                if (err_midsof) mid_seen++;
                if (err_nosof) nos_seen++;
            end
            e2 = e1;
            e1 = req_valid & req_sof;
            @(posedge clock_tb);
            #1;
            for (int r = 0; r < N; r++) begin
                if (took[r] && txq[r].size() > 0) void'(txq[r].pop_front());
                if (txq[r].size() > 0 && txq[r][0].gap > 0) begin
                    b = txq[r][0];
                    b.gap--;
                    txq[r][0] = b;
                    req_valid[r] = 1'b0;
                end else if (txq[r].size() > 0) begin
                    b = txq[r][0];
                    req_valid[r] = 1'b1;
                    req_sof[r] = b.sof;
                    req_eof[r] = b.eof;
                    req_data[r*128 +: 128] = b.d;
                    req_bytes[r*4 +: 4] = b.bytes;
                    req_block_tag[r*10 +: 10] = b.tag;
                end else begin
                    req_valid[r] = 1'b0;
                end
            end
        end
    end

    initial begin
        int nb, k;
        rst = 1'b1;
        req_valid = '0;
        req_sof = '0;
        req_eof = '0;
        req_data = '0;
        req_bytes = '0;
        req_block_tag = '0;
        repeat (3) @(negedge clock_tb);
        #1;
        check("rst_valid", sw_data_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_grant", grant_id, 2'd0);
        check("rst_ready", req_ready, '0);
        check("rst_err", {err_nosof, err_midsof}, 2'b00);
        rst = 1'b0;

        enq(0, 3, 4'd5, 10'h155, -1, 0, -1);
        drain(300);
        enq(1, 1, 4'd12, 10'h02a, -1, 0, -1);
        drain(300);
        enq(3, 3, 4'd15, 10'h3c3, 1, 4, -1);
        drain(300);
        enq(0, 1, 4'd2, 10'h011, -1, 0, -1);
        enq(2, 1, 4'd9, 10'h022, -1, 0, -1);
        enq(0, 1, 4'd7, 10'h033, -1, 0, -1);
        drain(300);
        stray(1);
        drain(300);
        check("nosof_pulses", nos_seen, 1);
        enq(2, 3, 4'd3, 10'h1ee, -1, 0, 1);
        drain(300);
        check("midsof_pulses", mid_seen, exp_mid);

        for (int it = 0; it < 40; it++) begin
            for (int r = 0; r < N; r++)
                if ($urandom_range(1, 0) == 1 || r == it % N)
                    repeat ($urandom_range(2, 1)) begin
                        nb = $urandom_range(4, 1);
                        enq(r, nb, 4'($urandom), 10'($urandom), $urandom_range(nb - 1, 0),
                            $urandom_range(3, 0), $urandom_range(3, 0) == 0 ? $urandom_range(nb, 1) : -1);
                    end
            drain(2000);
        end
        check("midsof_total", mid_seen, exp_mid);
        check("nosof_total", nos_seen, 1);

        enq(1, 1, 4'd4, 10'h101, -1, 0, -1);
        drain(300);
        sof_seen = 0;
        enq(0, 3, 4'd9, 10'h0f0, -1, 0, -1);
        k = 0;
        while (!sof_seen && k < 200) begin
            @(negedge clock_tb);
            #1;
            k++;
        end
        check("lo_reached", sof_seen, 1);
        rst = 1'b1;
        for (int r = 0; r < N; r++) begin
            txq[r].delete();
            exp_r[r].delete();
        end
        @(negedge clock_tb);
        #1;
        check("mrst_valid", sw_data_valid, 1'b0);
        check("mrst_data", {sw_data, sw_data_bytes, sw_sof, sw_eof}, '0);
        check("mrst_tag", sw_block_tag, 10'd0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_grant", grant_id, 2'd0);
        check("mrst_ready", req_ready, '0);
        check("mrst_err", {err_nosof, err_midsof}, 2'b00);
        rst = 1'b0;
        mptr = 0;
        cur = 0;
        enq(2, 2, 4'd6, 10'h2b2, -1, 0, -1);
        enq(0, 2, 4'd14, 10'h1a0, -1, 0, -1);
        drain(300);
        check("final_midsof", mid_seen, exp_mid);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/eth_sw_frame_arbiter.md
Name: eth_sw_frame_arbiter

Overview:
Frame-level round-robin arbiter that shares the 64-bit switch egress bus between N_REQ 128-bit ingress requesters.
- Grants one requester for a whole frame (sof through eof).
- Down-converts each 128-bit beat into one or two 64-bit sw_* beats.
- Applies backpressure through per-requester ready.
- Sits between the ingress port logic and the switch output stage.

Parameters:
N_REQ, 4, number of requesters (2..8)
GW, $clog2(N_REQ), grant index width (derived, not overridden)

Ports:
clock  in  1  system clock, all logic on posedge
rst  in  1  synchronous active-high reset
req_valid  in  N_REQ  per-requester beat valid
req_data  in  N_REQ*128  per-requester beat; slice i = [i*128 +: 128]
req_bytes  in  N_REQ*4  valid bytes minus 1; meaningful on eof beat only
req_sof  in  N_REQ  first beat of frame
req_eof  in  N_REQ  last beat of frame
req_block_tag  in  N_REQ*10  frame tag; sampled on sof beat
req_ready  out  N_REQ  beat accepted when req_valid[i] && req_ready[i]
sw_data_valid  out  1  egress beat valid
sw_data  out  64  egress data
sw_data_bytes  out  3  valid bytes minus 1
sw_sof  out  1  first egress beat of frame
sw_eof  out  1  last egress beat of frame
sw_block_tag  out  10  tag of the current frame, held on every beat
grant_id  out  GW  requester owning the bus
busy  out  1  frame in progress (state != IDLE)
err_nosof  out  1  one-cycle pulse: non-sof beat dropped in IDLE
err_midsof  out  1  one-cycle pulse: sof seen mid-frame

Behaviour:
- Reset (synchronous, rst=1): state IDLE; rr_ptr=0; grant_id=0; hold register empty; all sw_* outputs, busy and err_* = 0; req_ready forced 0 while rst=1.
- FSM states:
  - IDLE: no frame.
  - WAIT: frame granted, hold register empty.
  - HI: emit upper half of the held beat.
  - LO: emit lower half of the held beat.
- IDLE:
  - Eligible set = req_valid & req_sof.
  - Pick the first eligible index at or after rr_ptr, wrapping.
  - req_ready[winner]=1 combinationally; beat loads hold reg; grant_id<=winner; tag latched; next state HI.
  - Any requester with valid & !sof in IDLE: ready=1, beat dropped, err_nosof pulse. Winner takes precedence; the drop is still flagged.
- HI:
  - sw_data<=hold[127:64]; sw_sof<=first beat of frame.
  - Beat not eof, or req_bytes>=8: sw_data_bytes<=7, sw_eof<=0, next LO.
  - Beat eof with req_bytes<=7: sw_data_bytes<=req_bytes, sw_eof<=1, next IDLE, rr_ptr<=grant_id+1 mod N_REQ.
- LO:
  - sw_data<=hold[63:0], sw_sof<=0.
  - If held beat eof: sw_data_bytes<=req_bytes-8, sw_eof<=1, next IDLE, rr_ptr advances.
  - Else req_ready[grant_id]=1: accept → HI (back-to-back, no bubble); no valid → WAIT.
- WAIT: req_ready[grant_id]=1; accept → HI; otherwise stay. No timeout.
- Accepted beat with sof=1 in WAIT or LO: err_midsof pulse; sof ignored; beat treated as continuation.
- Registered outputs:
  - sw_data_valid=1 for exactly one cycle per emitted half.
  - Upper half visible the cycle after the accept edge; lower half the cycle after that.
- Frame ending on an eof beat always returns through IDLE (one-cycle arbitration bubble); non-granted requesters see ready=0 throughout the frame.
- Throughput: max one 128-bit beat per 2 cycles per frame.
- Reset mid-frame: frame truncated silently; no eof emitted.

Decomposition:
- Package eth_sw_pkg:
  - state enum {IDLE, WAIT, HI, LO}
  - widths: IN_W=128, SW_W=64, TAG_W=10, IN_BYTES_W=4, SW_BYTES_W=3
- Sub-module eth_rr_pick (N_REQ): combinational; inputs request vector and rr_ptr; outputs one-hot grant, index, any.

Test Plan:
- Single frame, req0, 3 beats, eof req_bytes=5, tag 0x155 → 5 sw beats; bytes 7,7,7,7,5; sof on beat 1, eof on beat 5; tag 0x155 on all.
- Long eof, req1 single beat sof+eof, req_bytes=12 → 2 sw beats, bytes 7 then 4, sof on first, eof on second.
- Contention, req0 and req2 raise sof same cycle, each 1-beat frame → grant 0 then 2; req0 re-requests → granted again only after req2 completes (rr_ptr=3 wraps to 0).
- Ingress gap: req3 stalls 4 cycles mid-frame → WAIT for 4 cycles, sw_data_valid low, no other grant; frame resumes intact.
- Protocol errors:
  - req1 valid without sof in IDLE → beat dropped, err_nosof=1 for 1 cycle.
  - sof mid-frame → err_midsof=1, data passed as continuation.
- rst asserted during LO → next cycle all outputs 0, state IDLE; new frame from req0 fully correct afterwards.
